// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter: FSM states, duty width and
// divider iteration count.
package pwm_duty_meter_pkg;

    // Duty is reported on the same 0..255 scale as the LED PWM generator.
    localparam int unsigned DUTY_W    = 8;

    // One quotient bit per iteration of the fractional divider.
    localparam int unsigned DIV_ITERS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } meter_state_t;

endpackage

// File: rtl/pwm_frac_div.sv
// Restoring fractional divider: q = floor((num << DUTY_W) / den), one
// quotient bit per clock after a single load cycle. Saturates to all-ones
// when num >= den.
module pwm_frac_div
    import pwm_duty_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] q
);

    localparam int unsigned ITER_W = $clog2(DIV_ITERS);

    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_den;
    logic [DUTY_W-1:0] r_q;
    logic [ITER_W-1:0] r_iter;
    logic              r_busy;
    logic              r_done;
    logic              r_sat;

    logic [CNT_W:0]    w_diff;
    logic              w_ge;
    logic [CNT_W-1:0]  w_rem_next;

    // One restoring step: doubled remainder minus divisor; the sign bit of
    // the difference decides the quotient bit (remainder < den keeps the
    // doubled value inside CNT_W+1 bits).
    always_comb begin
        w_diff     = {r_rem, 1'b0} - {1'b0, r_den};
        w_ge       = ~w_diff[CNT_W];
        w_rem_next = w_ge ? w_diff[CNT_W-1:0] : {r_rem[CNT_W-2:0], 1'b0};
    end

    // Load operands on start, then shift in one quotient bit per clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_q    <= '0;
            r_iter <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_busy <= 1'b1;
                r_rem  <= num;
                r_den  <= den;
                r_sat  <= (num >= den);
                r_q    <= '0;
                r_iter <= '0;
            end else if (r_busy) begin
                r_rem  <= w_rem_next;
                r_q    <= {r_q[DUTY_W-2:0], w_ge};
                r_iter <= r_iter + ITER_W'(1);
                if (r_iter == ITER_W'(DIV_ITERS - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign q    = r_sat ? '1 : r_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: synchronises an asynchronous PWM input, measures period
// and high time in clk cycles, and reports duty on a 0..255 scale with a
// one-cycle valid pulse. Flags a stuck input (timeout) and dropped
// measurements (overrun).
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = 18,
    parameter int unsigned MIN_PERIOD = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              duty_valid,
    output logic              no_signal,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Input path
    logic              r_sync1;
    logic              r_sync2;
    logic              r_hist;
    logic              w_rise;
    logic              w_fall;

    // Measurement
    meter_state_t      r_state;
    meter_state_t      w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_high;
    logic [CNT_W-1:0]  r_per_snap;
    logic              r_armed;
    logic              w_timeout;
    logic              w_period_ok;

    // FSM controls
    logic              w_cnt_restart;
    logic              w_latch_high;
    logic              w_div_start;
    logic              w_set_overrun;
    logic              w_timeout_fire;

    // Divider
    logic              w_div_busy;
    logic              w_div_done;
    logic [DUTY_W-1:0] w_div_q;

    // Output registers
    logic [DUTY_W-1:0] r_duty;
    logic [CNT_W-1:0]  r_period;
    logic              r_duty_valid;
    logic              r_no_signal;
    logic              r_overrun;

    // Two-flop synchroniser plus history flop. Left out of reset so that a
    // short reset while the pin is high cannot fabricate a rising edge.
    always_ff @(posedge clk) begin
        r_sync1 <= pwm_in;
        r_sync2 <= r_sync1;
        r_hist  <= r_sync2;
    end

    assign w_rise      = r_sync2 & ~r_hist;
    assign w_fall      = ~r_sync2 & r_hist;
    assign w_period_ok = (r_cnt >= CNT_W'(MIN_PERIOD));
    // A rise on the same cycle as the timeout is a normal period end.
    assign w_timeout   = r_armed & (r_cnt == CNT_MAX) & ~w_rise;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_restart  = 1'b0;
        w_latch_high   = 1'b0;
        w_div_start    = 1'b0;
        w_set_overrun  = 1'b0;
        w_timeout_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_cnt_restart = 1'b1;
                    w_state_next  = ST_HIGH;
                end else if (w_timeout) begin
                    w_timeout_fire = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_latch_high = 1'b1;
                    w_state_next = ST_LOW;
                end else if (w_timeout) begin
                    w_timeout_fire = 1'b1;
                    w_state_next   = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_cnt_restart = 1'b1;
                    w_state_next  = ST_HIGH;
                    if (w_period_ok) begin
                        if (w_div_busy) begin
                            w_set_overrun = 1'b1;
                        end else begin
                            w_div_start = 1'b1;
                        end
                    end
                end else if (w_timeout) begin
                    w_timeout_fire = 1'b1;
                    w_state_next   = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Free-running saturating counter; holds clocks elapsed since the last
    // detected rise (or reset), counting the restart cycle as 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= CNT_W'(1);
        end else if (w_cnt_restart) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Timeout arming: one timeout per stuck episode, re-armed by any rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_armed <= 1'b1;
        end else if (w_rise) begin
            r_armed <= 1'b1;
        end else if (w_timeout_fire) begin
            r_armed <= 1'b0;
        end
    end

    // High-time latch on fall and period snapshot on divider start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_high     <= '0;
            r_per_snap <= '0;
        end else begin
            if (w_latch_high) begin
                r_high <= r_cnt;
            end
            if (w_div_start) begin
                r_per_snap <= r_cnt;
            end
        end
    end

    pwm_frac_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_div_start),
        .num   (r_high),
        .den   (r_cnt),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .q     (w_div_q)
    );

    // Output registers: divider result or timeout report, plus sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_duty       <= '0;
            r_period     <= '0;
            r_duty_valid <= 1'b0;
            r_no_signal  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            if (w_div_done) begin
                r_duty       <= w_div_q;
                r_period     <= r_per_snap;
                r_duty_valid <= 1'b1;
                r_no_signal  <= 1'b0;
            end else if (w_timeout_fire) begin
                r_duty       <= {DUTY_W{r_sync2}};
                r_period     <= CNT_MAX;
                r_duty_valid <= 1'b1;
                r_no_signal  <= 1'b1;
            end
            if (w_set_overrun) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign duty       = r_duty;
    assign period     = r_period;
    assign duty_valid = r_duty_valid;
    assign no_signal  = r_no_signal;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter. A reduced counter width keeps the
// timeout cases short. An event-level model turns pin edges into expected
// duty/period reports; directed sequences add hand-computed expectations.
module tb_pwm_duty_meter;

    localparam int unsigned CNT_W = 12;
    localparam int          MINP  = 10;
    localparam int          MAXC  = (1 << CNT_W) - 1;
    // Pin change at a negedge -> sampled next edge -> 2 more flops -> FSM.
    localparam int          DET   = 2;
    localparam int          DIVL  = 9;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             pwm_in = 1'b0;
    logic [7:0]       duty;
    logic [CNT_W-1:0] period;
    logic             duty_valid;
    logic             no_signal;
    logic             overrun;

    pwm_duty_meter #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (MINP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .period     (period),
        .duty_valid (duty_valid),
        .no_signal  (no_signal),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc     = 0;
    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int at;
        int duty;
        int per;
        bit nosig;
    } ev_t;

    ev_t evq[$];
    bit  p0, p1, p2, p3;
    bit  locked, have_fall, armed;
    int  last_rise, fall_t, ref_t;
    int  exp_duty, exp_per;
    bit  exp_nosig;

    // Pin samples -> detected edges (fixed latency) -> periods and reports.
    always @(posedge clk) begin
        bit d, dp;
        int per, hi, q;
        cyc++;
        p3 = p2; p2 = p1; p1 = p0; p0 = pwm_in;
        d  = p2;
        dp = p3;
        if (!rst_n) begin
            evq.delete();
            locked    = 1'b0;
            have_fall = 1'b0;
            armed     = 1'b1;
            ref_t     = cyc;
            exp_duty  = 0;
            exp_per   = 0;
            exp_nosig = 1'b0;
        end else if (d && !dp) begin
            if (locked && have_fall) begin
                per = cyc - last_rise;
                if (per > MAXC) per = MAXC;
                if (per >= MINP) begin
                    hi = fall_t - last_rise;
                    q  = (hi * 256) / per;
                    if (q > 255) q = 255;
                    evq.push_back('{cyc + DIVL, q, per, 1'b0});
                end
            end
            locked    = 1'b1;
            have_fall = 1'b0;
            last_rise = cyc;
            ref_t     = cyc;
            armed     = 1'b1;
        end else if (!d && dp && locked && !have_fall) begin
            fall_t    = cyc;
            have_fall = 1'b1;
        end else if (armed && (cyc - ref_t) >= MAXC) begin
            evq.push_back('{cyc, d ? 255 : 0, MAXC, 1'b1});
            armed     = 1'b0;
            locked    = 1'b0;
            have_fall = 1'b0;
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        bit ev;
        if (cyc > 0) begin
            ev = 1'b0;
            if (evq.size() > 0) begin
                if (evq[0].at == cyc) begin
                    ev        = 1'b1;
                    exp_duty  = evq[0].duty;
                    exp_per   = evq[0].per;
                    exp_nosig = evq[0].nosig;
                    void'(evq.pop_front());
                end
            end
            check("duty_valid", int'(duty_valid), int'(ev));
            check("duty",       int'(duty),       exp_duty);
            check("period",     int'(period),     exp_per);
            check("no_signal",  int'(no_signal),  int'(exp_nosig));
            check("overrun",    int'(overrun),    0);
            if (duty_valid) n_valid++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int per, input int reps);
        for (int i = 0; i < reps; i++) begin
            pwm_in = 1'b1;
            hold(hi);
            pwm_in = 1'b0;
            hold(per - hi);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_duty"},      int'(duty),       0);
        check({tag, "_period"},    int'(period),     0);
        check({tag, "_valid"},     int'(duty_valid), 0);
        check({tag, "_no_signal"}, int'(no_signal),  0);
        check({tag, "_overrun"},   int'(overrun),    0);
    endtask

    initial begin
        int c0, lat;

        // Reset state
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        hold(5);
        rst_n = 1'b1;
        check_zero_outputs("reset");

        // Constant low from reset: single timeout report
        hold(MAXC + 20);
        check("lowto_count",     n_valid,          1);
        check("lowto_duty",      int'(duty),       0);
        check("lowto_period",    int'(period),     4095);
        check("lowto_no_signal", int'(no_signal),  1);

        // Square wave 64/256
        pulse(64, 256, 4);
        check("sq_count",     n_valid,         4);
        check("sq_duty",      int'(duty),      64);
        check("sq_period",    int'(period),    256);
        check("sq_no_signal", int'(no_signal), 0);

        // Generator-style 508/1024 with a pin-to-valid latency probe
        pwm_in = 1'b1;
        c0  = cyc;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (duty_valid && lat < 0) lat = cyc - c0;
        end
        check("latency", lat, 12);
        hold(508 - 40);
        pwm_in = 1'b0;
        hold(1024 - 508);
        pulse(508, 1024, 2);
        check("gen127_duty",   int'(duty),   127);
        check("gen127_period", int'(period), 1024);
        pulse(1020, 1024, 3);
        check("gen255_duty",   int'(duty),   255);
        check("gen255_period", int'(period), 1024);

        // Short glitch period is discarded
        pulse(128, 256, 2);
        c0 = n_valid;
        pulse(2, 6, 1);
        pulse(128, 256, 2);
        check("glitch_count",   n_valid - c0,  2);
        check("glitch_duty",    int'(duty),    128);
        check("glitch_overrun", int'(overrun), 0);

        // Minimum-period boundary: 10 accepted, 9 rejected
        pulse(3, 10, 4);
        check("min10_duty",   int'(duty),   76);
        check("min10_period", int'(period), 10);
        pulse(3, 9, 4);
        hold(30);
        check("min9_duty",   int'(duty),   76);
        check("min9_period", int'(period), 10);

        // Stuck high after a 50% stream, then resume
        pulse(128, 256, 3);
        c0 = n_valid;
        pwm_in = 1'b1;
        hold(MAXC + 50);
        check("hito_count",     n_valid - c0,    2);
        check("hito_duty",      int'(duty),      255);
        check("hito_period",    int'(period),    4095);
        check("hito_no_signal", int'(no_signal), 1);
        pulse(128, 256, 3);
        check("resume_duty",      int'(duty),      128);
        check("resume_period",    int'(period),    256);
        check("resume_no_signal", int'(no_signal), 0);

        // One-clock reset while a divide is in flight
        pwm_in = 1'b1;
        hold(6);
        rst_n = 1'b0;
        hold(1);
        rst_n = 1'b1;
        c0 = n_valid;
        check_zero_outputs("middiv");
        hold(121);
        pwm_in = 1'b0;
        hold(128);
        pulse(128, 256, 3);
        check("middiv_count",  n_valid - c0, 2);
        check("middiv_duty",   int'(duty),   128);
        check("middiv_period", int'(period), 256);

        hold(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to have finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
